// File: rtl/swapout_request_scheduler_if.sv
// Request/grant bus between the swapout requesters, the scheduler and the sequence-start controller.
// All signals live in the event generator TX clock domain.
interface swapout_request_scheduler_if #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned OFFSET_WIDTH = 16
);
  localparam int unsigned GidW = $clog2(NREQ);

  logic [NREQ-1:0]              evgRequest;
  logic [NREQ*OFFSET_WIDTH-1:0] evgRequestOffset;
  logic                         evgEnable;
  logic                         evgClearStatus;
  logic                         evgSwapDone;
  logic                         evgSwapStart;
  logic [OFFSET_WIDTH-1:0]      evgSwapOffset;
  logic [GidW-1:0]              evgGrantId;
  logic                         evgBusy;
  logic [NREQ-1:0]              evgPending;
  logic [NREQ-1:0]              evgOverrun;
  logic                         evgTimeout;

  modport master (
    output evgRequest, evgRequestOffset, evgEnable, evgClearStatus, evgSwapDone,
    input  evgSwapStart, evgSwapOffset, evgGrantId, evgBusy, evgPending, evgOverrun, evgTimeout
  );

  modport slave (
    input  evgRequest, evgRequestOffset, evgEnable, evgClearStatus, evgSwapDone,
    output evgSwapStart, evgSwapOffset, evgGrantId, evgBusy, evgPending, evgOverrun, evgTimeout
  );
endinterface

// File: rtl/swapout_request_scheduler.sv
// Round-robin scheduler that serialises latched swapout requests into the sequence-start
// controller, waiting for completion (with timeout) and a holdoff between grants.
module swapout_request_scheduler #(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned OFFSET_WIDTH   = 16,
  parameter int unsigned HOLDOFF_CLOCKS = 1000,
  parameter int unsigned TIMEOUT_CLOCKS = 1000000
) (
  input  logic                       evgTxClk,
  input  logic                       evgTxRst_n,
  swapout_request_scheduler_if.slave bus
);
  localparam int unsigned GidW   = $clog2(NREQ);
  localparam int unsigned CntMax = (TIMEOUT_CLOCKS > HOLDOFF_CLOCKS) ? TIMEOUT_CLOCKS
                                                                     : HOLDOFF_CLOCKS;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] TimeoutLoad = CntW'(TIMEOUT_CLOCKS - 1);
  localparam logic [CntW-1:0] HoldoffLoad = CntW'(HOLDOFF_CLOCKS - 1);
  localparam logic [GidW-1:0] PtrReset    = GidW'(NREQ - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone, StHoldoff} state_e;

  state_e                              state_q, state_d;
  logic [CntW-1:0]                     cnt_q, cnt_d;
  logic [GidW-1:0]                     ptr_q, ptr_d, gid_q, gid_d;
  logic [NREQ-1:0]                     pending_q, pending_d, overrun_q, overrun_d;
  logic [NREQ-1:0][OFFSET_WIDTH-1:0]   slot_q, slot_d;
  logic [OFFSET_WIDTH-1:0]             offset_q, offset_d;
  logic                                start_q, start_d, busy_q, busy_d, timeout_q, timeout_d;
  logic                                grant_found, timeout_set;
  logic [GidW-1:0]                     grant_idx, rr_idx;
  logic [NREQ-1:0]                     grant_mask;
  logic [CntW-1:0]                     cnt_dec;

  assign cnt_dec = (cnt_q != '0) ? cnt_q - 1'b1 : '0;

  // First pending requester strictly after the last grant, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_idx      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      rr_idx = GidW'((32'(ptr_q) + k) % NREQ);
      if (!grant_found && pending_q[rr_idx]) begin
        grant_found = 1'b1;
        grant_idx   = rr_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    offset_d    = offset_q;
    start_d     = 1'b0;
    grant_mask  = '0;
    timeout_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.evgEnable && grant_found) begin
          state_d               = StIssue;
          grant_mask[grant_idx] = 1'b1;
          gid_d                 = grant_idx;
          ptr_d                 = grant_idx;
          offset_d              = slot_q[grant_idx];
          start_d               = 1'b1;
          // Loaded as ISSUE is entered so expiry lands TIMEOUT_CLOCKS after the start cycle.
          cnt_d                 = TimeoutLoad;
        end
      end
      StIssue: begin
        state_d = StWaitDone;
        cnt_d   = cnt_dec;
      end
      StWaitDone: begin
        if (bus.evgSwapDone) begin
          state_d = StHoldoff;
          cnt_d   = HoldoffLoad;
        end else if (cnt_q == '0) begin
          state_d     = StHoldoff;
          cnt_d       = HoldoffLoad;
          timeout_set = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      StHoldoff: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_dec;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // A strobe coinciding with its own grant re-arms the slot without counting as an overrun.
  always_comb begin
    pending_d = (pending_q & ~grant_mask) | bus.evgRequest;
    overrun_d = (bus.evgClearStatus ? '0 : overrun_q) | (bus.evgRequest & pending_q & ~grant_mask);
    timeout_d = (bus.evgClearStatus ? 1'b0 : timeout_q) | timeout_set;
    slot_d    = slot_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (bus.evgRequest[i]) slot_d[i] = bus.evgRequestOffset[i*OFFSET_WIDTH +: OFFSET_WIDTH];
    end
  end

  always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
    if (!evgTxRst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ptr_q     <= PtrReset;
      gid_q     <= '0;
      offset_q  <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      pending_q <= '0;
      overrun_q <= '0;
      slot_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gid_q     <= gid_d;
      offset_q  <= offset_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      slot_q    <= slot_d;
    end
  end

  assign bus.evgSwapStart  = start_q;
  assign bus.evgSwapOffset = offset_q;
  assign bus.evgGrantId    = gid_q;
  assign bus.evgBusy       = busy_q;
  assign bus.evgPending    = pending_q;
  assign bus.evgOverrun    = overrun_q;
  assign bus.evgTimeout    = timeout_q;
endmodule

// File: tb/tb_swapout_request_scheduler.sv
// Bench for swapout_request_scheduler: directed table and corner sequences, then random traffic
// compared cycle by cycle against a timestamp-based reference model.
module tb_swapout_request_scheduler;
  localparam int unsigned NREQ = 4;
  localparam int unsigned OW   = 16;
  localparam int unsigned HOLD = 5;
  localparam int unsigned TMO  = 50;
  localparam longint      Never = 64'sh7fff_ffff_ffff_ffff;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  swapout_request_scheduler_if #(.NREQ(NREQ), .OFFSET_WIDTH(OW)) bus ();

  swapout_request_scheduler #(
    .NREQ(NREQ), .OFFSET_WIDTH(OW), .HOLDOFF_CLOCKS(HOLD), .TIMEOUT_CLOCKS(TMO)
  ) dut (
    .evgTxClk  (clk),
    .evgTxRst_n(rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sequence timing expressed as absolute cycle stamps.
  longint          cyc, idle_at, s_at;
  bit              wopen;
  int              m_ptr;
  logic [NREQ-1:0] m_pend, m_over;
  logic [OW-1:0]   m_slot[NREQ];
  logic            m_start, m_busy, m_to;
  logic [OW-1:0]   m_off;
  logic [1:0]      m_gid;

  task automatic model_reset();
    cyc = 0; idle_at = 0; s_at = 0; wopen = 0; m_ptr = NREQ - 1;
    m_pend = '0; m_over = '0; m_start = 0; m_busy = 0; m_to = 0; m_off = '0; m_gid = '0;
    for (int i = 0; i < NREQ; i++) m_slot[i] = '0;
  endtask

  task automatic model_step();
    logic [NREQ-1:0] req, gmask;
    logic [1:0]      idx;
    int              g;
    bit              to_set;
    req = bus.evgRequest; gmask = '0; to_set = 0; m_start = 0;
    if (cyc >= idle_at && bus.evgEnable && m_pend != '0) begin
      g = -1;
      for (int k = 1; k <= NREQ; k++) begin
        idx = 2'((m_ptr + k) % NREQ);
        if (g < 0 && m_pend[idx]) g = int'(idx);
      end
      gmask[g] = 1'b1;
      m_off = m_slot[g]; m_gid = 2'(g); m_ptr = g; m_start = 1;
      s_at = cyc + 1; idle_at = Never; wopen = 1;
    end else if (wopen && cyc > s_at) begin
      if (bus.evgSwapDone) begin
        wopen = 0; idle_at = cyc + HOLD + 1;
      end else if (cyc == s_at + TMO - 1) begin
        wopen = 0; idle_at = cyc + HOLD + 1; to_set = 1;
      end
    end
    m_over = (bus.evgClearStatus ? '0 : m_over) | (req & m_pend & ~gmask);
    m_to   = (bus.evgClearStatus ? 1'b0 : m_to) | to_set;
    m_pend = (m_pend & ~gmask) | req;
    for (int i = 0; i < NREQ; i++) if (req[i]) m_slot[i] = bus.evgRequestOffset[i*OW +: OW];
    m_busy = (cyc + 1) < idle_at;
    cyc++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("m_start",   bus.evgSwapStart,  m_start);
      chk("m_offset",  bus.evgSwapOffset, m_off);
      chk("m_gid",     bus.evgGrantId,    m_gid);
      chk("m_busy",    bus.evgBusy,       m_busy);
      chk("m_pending", bus.evgPending,    m_pend);
      chk("m_overrun", bus.evgOverrun,    m_over);
      chk("m_timeout", bus.evgTimeout,    m_to);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [NREQ-1:0] mask, input logic [NREQ*OW-1:0] offs);
    bus.evgRequest = mask;
    bus.evgRequestOffset = offs;
    tick();
    bus.evgRequest = '0;
  endtask

  task automatic pulse_done();
    bus.evgSwapDone = 1'b1;
    tick();
    bus.evgSwapDone = 1'b0;
  endtask

  task automatic wait_start(input int maxc, output int n);
    n = 0;
    while (bus.evgSwapStart !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    chk("start_seen", bus.evgSwapStart, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.evgBusy !== 1'b0 && n < int'(TMO + HOLD + 10)) begin
      tick();
      n++;
    end
    chk("idle_reached", bus.evgBusy, 1'b0);
  endtask

  // Waits for a start, checks the grant, answers with done one cycle later; returns the
  // number of ticks spent waiting.
  task automatic serve(input logic [1:0] gid, input logic [OW-1:0] off, output int n);
    wait_start(int'(TMO + HOLD + 10), n);
    chk("serve_gid", bus.evgGrantId, gid);
    chk("serve_off", bus.evgSwapOffset, off);
    tick();
    pulse_done();
  endtask

  typedef struct {
    int          id;
    logic [15:0] off;
    logic [3:0]  exp_pend;
    logic [1:0]  exp_gid;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    logic [NREQ*OW-1:0] offs;

    vecs[0] = '{id: 2, off: 16'h0123, exp_pend: 4'b0100, exp_gid: 2'd2};
    vecs[1] = '{id: 0, off: 16'hbeef, exp_pend: 4'b0001, exp_gid: 2'd0};
    vecs[2] = '{id: 1, off: 16'h5555, exp_pend: 4'b0010, exp_gid: 2'd1};
    vecs[3] = '{id: 3, off: 16'h0f0f, exp_pend: 4'b1000, exp_gid: 2'd3};

    bus.evgRequest = '0; bus.evgRequestOffset = '0; bus.evgEnable = 1'b1;
    bus.evgClearStatus = 1'b0; bus.evgSwapDone = 1'b0;
    repeat (3) tick();
    chk("rst_start", bus.evgSwapStart, 1'b0);
    chk("rst_busy", bus.evgBusy, 1'b0);
    chk("rst_pending", bus.evgPending, 4'b0);
    chk("rst_gid", bus.evgGrantId, 2'd0);
    chk("rst_offset", bus.evgSwapOffset, 16'h0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // Single requests: latency 2, grant values, holdoff length.
    for (int i = 0; i < 4; i++) begin
      offs = '0;
      offs[vecs[i].id*OW +: OW] = vecs[i].off;
      strobe(4'(1 << vecs[i].id), offs);
      chk("tbl_pend", bus.evgPending, vecs[i].exp_pend);
      chk("tbl_early", bus.evgSwapStart, 1'b0);
      tick();
      chk("tbl_start", bus.evgSwapStart, 1'b1);
      chk("tbl_off", bus.evgSwapOffset, vecs[i].off);
      chk("tbl_gid", bus.evgGrantId, vecs[i].exp_gid);
      chk("tbl_busy", bus.evgBusy, 1'b1);
      tick();
      tick();
      pulse_done();
      repeat (HOLD - 1) tick();
      chk("tbl_hold_busy", bus.evgBusy, 1'b1);
      tick();
      chk("tbl_hold_idle", bus.evgBusy, 1'b0);
    end

    // Round robin across sequences; back-to-back grants spaced by HOLD+2 after done.
    strobe(4'b1011, {16'ha003, 16'h0, 16'ha001, 16'ha000});
    serve(2'd0, 16'ha000, n);
    serve(2'd1, 16'ha001, n);
    chk("rr_spacing", n, HOLD + 1);
    serve(2'd3, 16'ha003, n);
    chk("rr_spacing2", n, HOLD + 1);
    wait_idle();
    strobe(4'b1001, {16'hb003, 16'h0, 16'h0, 16'hb000});
    serve(2'd0, 16'hb000, n);
    serve(2'd3, 16'hb003, n);
    wait_idle();

    // Overrun while disabled, then enable releases the grant next cycle.
    bus.evgEnable = 1'b0;
    strobe(4'b0010, 64'h0000_0000_0010_0000);
    strobe(4'b0010, 64'h0000_0000_0020_0000);
    chk("ovr_flag", bus.evgOverrun, 4'b0010);
    repeat (5) tick();
    chk("dis_pend", bus.evgPending, 4'b0010);
    chk("dis_start", bus.evgSwapStart, 1'b0);
    bus.evgEnable = 1'b1;
    tick();
    chk("en_start", bus.evgSwapStart, 1'b1);
    chk("ovr_off", bus.evgSwapOffset, 16'h0020);
    chk("ovr_gid", bus.evgGrantId, 2'd1);
    tick();
    pulse_done();
    bus.evgClearStatus = 1'b1;
    tick();
    bus.evgClearStatus = 1'b0;
    chk("ovr_clear", bus.evgOverrun, 4'b0);
    wait_idle();

    // Timeout exactly TMO cycles after the start, then a normal grant.
    strobe(4'b0100, 64'h0000_0bad_0000_0000);
    tick();
    chk("to_start", bus.evgSwapStart, 1'b1);
    repeat (TMO - 1) tick();
    chk("to_before", bus.evgTimeout, 1'b0);
    tick();
    chk("to_flag", bus.evgTimeout, 1'b1);
    repeat (HOLD - 1) tick();
    chk("to_hold_busy", bus.evgBusy, 1'b1);
    tick();
    chk("to_idle", bus.evgBusy, 1'b0);
    strobe(4'b0001, 64'h0000_0000_0000_7777);
    tick();
    chk("to_next_start", bus.evgSwapStart, 1'b1);
    chk("to_next_off", bus.evgSwapOffset, 16'h7777);
    tick();
    pulse_done();
    bus.evgClearStatus = 1'b1;
    tick();
    bus.evgClearStatus = 1'b0;
    chk("to_clear", bus.evgTimeout, 1'b0);
    wait_idle();

    // Asynchronous reset in WAIT_DONE with another request still pending.
    strobe(4'b1001, 64'h1234_0000_0000_5678);
    tick();
    tick();
    tick();
    chk("pre_rst_busy", bus.evgBusy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.evgBusy, 1'b0);
    chk("arst_pending", bus.evgPending, 4'b0);
    chk("arst_gid", bus.evgGrantId, 2'd0);
    chk("arst_offset", bus.evgSwapOffset, 16'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    strobe(4'b0100, 64'h0000_4321_0000_0000);
    chk("post_rst_pend", bus.evgPending, 4'b0100);
    tick();
    chk("post_rst_start", bus.evgSwapStart, 1'b1);
    chk("post_rst_gid", bus.evgGrantId, 2'd2);
    tick();
    pulse_done();
    wait_idle();

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      logic [NREQ-1:0] r;
      for (int i = 0; i < NREQ; i++) r[i] = ($urandom_range(11) == 0);
      bus.evgRequest       = r;
      bus.evgRequestOffset = {$urandom, $urandom};
      if ($urandom_range(99) == 0) bus.evgEnable = ~bus.evgEnable;
      bus.evgSwapDone      = ($urandom_range((c / 1000) % 2 == 0 ? 14 : 39) == 0);
      bus.evgClearStatus   = ($urandom_range(59) == 0);
      tick();
    end
    bus.evgRequest = '0; bus.evgSwapDone = 1'b0; bus.evgClearStatus = 1'b0;
    bus.evgEnable = 1'b1;
    repeat (TMO + HOLD + 5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/swapout_request_scheduler.md
# swapout_request_scheduler

Arbitrates swapout (accumulator/storage swap) requests from several independent requesters and sequences them one at a time into the swapout sequence-start controller in the event generator TX clock domain. Per-requester requests are latched with their bucket offset, served round-robin, and each start is followed by a wait for sequencer completion (with timeout) and a mandatory holdoff before the next grant. Sticky overrun and timeout flags are exported for the system status register.

## Interface
- NREQ, 4: number of requesters (2..8).
- OFFSET_WIDTH, 16: width of the per-request offset passed to the sequencer.
- HOLDOFF_CLOCKS, 1000: minimum idle cycles after completion or timeout before the next grant (≥1).
- TIMEOUT_CLOCKS, 1000000: cycles allowed in WAIT_DONE before declaring timeout (≥1).

- evgTxClk  in  1  event generator TX clock; the only clock.
- evgTxRst_n  in  1  asynchronous, active-low reset.
- evgRequest  in  NREQ  single-cycle request strobes, one per requester.
- evgRequestOffset  in  NREQ*OFFSET_WIDTH  per-requester offset; requester i uses bits [i*OFFSET_WIDTH +: OFFSET_WIDTH], sampled when evgRequest[i]=1.
- evgEnable  in  1  when low, no new grant is issued; pending requests are retained.
- evgClearStatus  in  1  single-cycle strobe that clears evgOverrun and evgTimeout.
- evgSwapDone  in  1  completion pulse from the swapout sequencer.
- evgSwapStart  out  1  one-cycle start pulse to the sequencer.
- evgSwapOffset  out  OFFSET_WIDTH  offset of the current grant; valid with evgSwapStart and held until the next grant.
- evgGrantId  out  $clog2(NREQ)  index of the current or most recent grant.
- evgBusy  out  1  high whenever state ≠ IDLE.
- evgPending  out  NREQ  latched, not-yet-granted requests.
- evgOverrun  out  NREQ  sticky: request i arrived while pending[i] was already set.
- evgTimeout  out  1  sticky: a WAIT_DONE timed out.

## Operation
- Reset (asynchronous, takes effect immediately): state IDLE, all outputs 0, pending and offset slots 0, round-robin pointer = NREQ-1 so requester 0 has first priority.
- Request latch: evgRequest[i] sets pending[i] and overwrites slot i with the sampled offset. If pending[i] is already set, evgOverrun[i] is set and the newer offset replaces the older one (only one swap is queued per requester).
- States: IDLE, ISSUE, WAIT_DONE, HOLDOFF.
- IDLE: if evgEnable=1 and pending≠0, grant the first set bit searching upward (with wrap-around) from pointer+1. Latch evgSwapOffset and evgGrantId, clear that pending bit, set pointer = grant index, go to ISSUE.
- ISSUE: evgSwapStart=1 for exactly this cycle. Load the timeout counter with TIMEOUT_CLOCKS-1, go to WAIT_DONE.
- WAIT_DONE: evgSwapDone=1 goes to HOLDOFF. On timeout-counter expiry without done, set evgTimeout and go to HOLDOFF. Done and expiry in the same cycle count as done.
- HOLDOFF: counter loaded with HOLDOFF_CLOCKS-1 on entry and decremented each cycle; at 0, go to IDLE.
- evgSwapDone outside WAIT_DONE is ignored.
- Simultaneous request and grant for the same requester: the grant clears the old pending bit, the new strobe sets it again with the new offset, and no overrun is flagged. The granted offset is the pre-strobe value.
- evgEnable falling mid-sequence: the sequence in progress runs through WAIT_DONE and HOLDOFF. The block then stalls in IDLE.
- evgClearStatus coincident with a new overrun or timeout: the set wins.
- Counter widths come from $clog2 of the parameter values. Counters never wrap: they are reloaded on every state entry.

## Timing
- All outputs are registered.
- Idle block, evgEnable=1: strobe in cycle 0 gives pending visible in cycle 1 and evgSwapStart in cycle 2 (latency 2).
- Done in cycle 0: the next evgSwapStart, if pending, comes in cycle HOLDOFF_CLOCKS+2.
- Timeout: evgTimeout rises TIMEOUT_CLOCKS cycles after the evgSwapStart cycle.
- evgBusy rises in the evgSwapStart cycle and falls on the first IDLE cycle.

## Test plan
- Reset, then strobe requester 2 with offset 0x0123 -> evgSwapStart 2 cycles later, evgSwapOffset=0x0123, evgGrantId=2. Pulse done -> next start is not before HOLDOFF_CLOCKS+2 cycles.
- Strobe requesters 0, 1 and 3 together and answer each start with done -> grant order 0, 1, 3. Then strobe 0 and 3 together -> order 0, 3. The round-robin pointer is respected across sequences.
- Strobe requester 1 twice (offsets 0x10 then 0x20) before its grant -> evgOverrun=0b0010, granted offset 0x20. evgClearStatus -> evgOverrun=0.
- Grant with no done, using TIMEOUT_CLOCKS=50 -> evgTimeout=1 exactly 50 cycles after start. Block returns to IDLE after holdoff, and a later grant proceeds normally.
- evgEnable=0 with requests pending -> no start and evgPending holds. Raise evgEnable -> start in the next cycle after IDLE evaluation.
- Assert evgTxRst_n low during WAIT_DONE -> all outputs 0 immediately. After release, a new request is served with latency 2.
